// File: rtl/i2c_tx_shifter.sv
// Slave-side I2C transmit shifter: pops FIFO bytes and shifts them MSB-first onto open-drain SDA.
// Optional clock stretching on FIFO underrun is enabled with `define I2C_TX_CLK_STRETCH_EN.
module i2c_tx_shifter #(
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    input  logic       tx_start,
    input  logic       stop_det,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       rd_en_tx,
    output logic       sda_oe,
    output logic       scl_oe,
    output logic       busy,
    output logic       byte_done,
    output logic       nack,
    output logic       underrun
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_STRETCH = 3'd5;

    logic [2:0]             state;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;
    logic                   ack_bit;
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   scl_rise;
    logic                   scl_fall;

    // Synchronizers reset high so an idle bus produces no spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise =  scl_s & ~scl_d;
    assign scl_fall = ~scl_s &  scl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ack_bit   <= 1'b0;
            byte_done <= 1'b0;
            nack      <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            nack      <= 1'b0;
            if (stop_det) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (tx_start) state <= S_FETCH;
                    end
                    S_FETCH: begin
                        if (!fifo_empty) begin
                            state <= S_LOAD;
                        end else begin
`ifdef I2C_TX_CLK_STRETCH_EN
                            state <= S_STRETCH;
`else
                            shreg   <= FILL_BYTE;
                            bit_cnt <= 3'd7;
                            state   <= S_SEND;
`endif
                        end
                    end
                    S_STRETCH: begin
                        if (!fifo_empty) state <= S_LOAD;
                    end
                    S_LOAD: begin
                        shreg   <= fifo_data;
                        bit_cnt <= 3'd7;
                        state   <= S_SEND;
                    end
                    S_SEND: begin
                        if (scl_fall) begin
                            if (bit_cnt != 3'd0) begin
                                shreg   <= {shreg[6:0], 1'b0};
                                bit_cnt <= bit_cnt - 3'd1;
                            end else begin
                                state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (scl_rise) begin
                            ack_bit   <= sda_s;
                            byte_done <= 1'b1;
                            nack      <= sda_s;
                        end else if (scl_fall) begin
                            state <= ack_bit ? S_IDLE : S_FETCH;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign rd_en_tx = ~stop_det & ~fifo_empty & ((state == S_FETCH) | (state == S_STRETCH));
    assign sda_oe   = (state == S_SEND) & ~shreg[7];
    assign busy     = (state != S_IDLE);

`ifdef I2C_TX_CLK_STRETCH_EN
    logic stretched;

    // SCL stays held through LOAD so the first bit is on SDA before the master may clock it.
    always_ff @(posedge clk) begin
        if (rst || stop_det) begin
            stretched <= 1'b0;
        end else if (state == S_FETCH && fifo_empty) begin
            stretched <= 1'b1;
        end else if (state == S_LOAD) begin
            stretched <= 1'b0;
        end
    end

    assign scl_oe   = stretched;
    assign underrun = 1'b0;
`else
    assign scl_oe   = 1'b0;
    assign underrun = ~stop_det & fifo_empty & (state == S_FETCH);
`endif

endmodule
